// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between two requesters, the
// response consumer and alu_arbiter.
//   master : requester/consumer side (drives reqN_valid/operands, rsp_ready)
//   slave  : arbiter side (drives reqN_ready and all rsp_* fields)
interface alu_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_rs1;
  logic [WIDTH-1:0] req0_rs2;
  logic [SEL_W-1:0] req0_sel;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_rs1;
  logic [WIDTH-1:0] req1_rs2;
  logic [SEL_W-1:0] req1_sel;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_rs1, req0_rs2, req0_sel,
    output req1_valid, req1_rs1, req1_rs2, req1_sel,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_rs1, req0_rs2, req0_sel,
    input  req1_valid, req1_rs1, req1_rs2, req1_sel,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter sharing one combinational ALU.
// Accepts one op at a time in IDLE, drives the ALU from registers for one
// EXEC cycle, then holds the captured result in RESP until consumed.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : req0_*/req1_* request channels, rsp_* response channel
//   alu_rs1/rs2/sel     : registered operands/op select to the ALU
//   alu_result/alu_zero : combinational ALU outputs
// Optional feature: define ALU_ARB_OPCHECK_EN to reject unsupported op
// selects with rsp_err=1 (no ALU cycle spent). Undefined: rsp_err is 0.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_rs1,
  output logic [WIDTH-1:0] alu_rs2,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             prio;
  logic             id_q;
  logic             grant0, grant1;
  logic             hs, hs_id;
  logic [WIDTH-1:0] hs_rs1, hs_rs2;
  logic [SEL_W-1:0] hs_sel;
  logic             op_bad;
  logic             rsp_id_q, rsp_zero_q;
  logic [WIDTH-1:0] rsp_result_q;

  // Round-robin grant: uncontended requester wins, otherwise prio decides.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || !prio);
    grant1 = bus.req1_valid && (!bus.req0_valid ||  prio);
  end

  assign bus.req0_ready = (state == IDLE) && !rst && grant0;
  assign bus.req1_ready = (state == IDLE) && !rst && grant1;

  assign hs     = bus.req0_ready || bus.req1_ready;
  assign hs_id  = bus.req1_ready;
  assign hs_rs1 = hs_id ? bus.req1_rs1 : bus.req0_rs1;
  assign hs_rs2 = hs_id ? bus.req1_rs2 : bus.req0_rs2;
  assign hs_sel = hs_id ? bus.req1_sel : bus.req0_sel;

`ifdef ALU_ARB_OPCHECK_EN
  logic rsp_err_q;

  function automatic logic sel_legal(input logic [SEL_W-1:0] s);
    case (s)
      SEL_W'(0), SEL_W'(1), SEL_W'(2), SEL_W'(3), SEL_W'(4),
      SEL_W'(6), SEL_W'(7), SEL_W'(10), SEL_W'(13), SEL_W'(14):
        sel_legal = 1'b1;
      default:
        sel_legal = 1'b0;
    endcase
  endfunction

  assign op_bad      = hs && !sel_legal(hs_sel);
  assign bus.rsp_err = rsp_err_q;
`else
  assign op_bad      = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (hs) state_nxt = op_bad ? RESP : EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio         <= 1'b0;
      id_q         <= 1'b0;
      alu_rs1      <= '0;
      alu_rs2      <= '0;
      alu_sel      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      if (hs) begin
        prio <= !hs_id;
        if (!op_bad) begin
          alu_rs1 <= hs_rs1;
          alu_rs2 <= hs_rs2;
          alu_sel <= hs_sel;
          id_q    <= hs_id;
        end
`ifdef ALU_ARB_OPCHECK_EN
        else begin
          // Rejected op goes straight to RESP; ALU registers keep old values.
          rsp_id_q     <= hs_id;
          rsp_result_q <= '0;
          rsp_zero_q   <= 1'b0;
          rsp_err_q    <= 1'b1;
        end
`endif
      end
      if (state == EXEC) begin
        rsp_id_q     <= id_q;
        rsp_result_q <= alu_result;
        rsp_zero_q   <= alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
        rsp_err_q    <= 1'b0;
`endif
      end
    end
  end

  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

endmodule
